mult_seq: RTL

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 88 ++++++++
 1 files changed

// File: rtl/mult_seq.sv
// mult_seq: 32-bit signed radix-2 Booth multiplier that uses an external shared adder
module mult_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] adder_sum,
  input  logic        adder_cout,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  output logic        adder_cin,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] m_q, m_d, a_q, a_d, q_q, q_d;
  logic        q1_q, q1_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        s;
  // Booth recoding of {Q[0],q_1}: add M, subtract M via ~M+1, or pass A through
  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (state_q == RUN) begin
      adder_a   = a_q;
      adder_b   = (q_q[0] ^ q1_q) ? (q_q[0] ? ~m_q : m_q) : '0;
      adder_cin = q_q[0] & ~q1_q;
    end
  end
  // Bit 32 of the sign-extended sum, used as the arithmetic-shift fill bit
  assign s = adder_a[31] ^ adder_b[31] ^ adder_cout;
  // Next state and datapath update
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        m_d     = opA;
        a_d     = '0;
        q_d     = opB;
        q1_d    = 1'b0;
        cnt_d   = '0;
      end
      RUN: if (cancel) state_d = IDLE;
      else begin
        a_d     = {s, adder_sum[31:1]};
        q_d     = {adder_sum[0], q_q[31:1]};
        q1_d    = q_q[0];
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy         = (state_q == RUN) || (state_q == DONE);
  assign result_valid = (state_q == DONE);
  assign result       = q_q;
  assign ovf          = !((&{a_q, q_q[31]}) || !(|{a_q, q_q[31]}));
endmodule
